// File: rtl/bsg_axi_rd_arbiter.sv
// Arbitrates N AXI read requesters onto one slave port, one burst outstanding at a time.
// Define BSG_AXI_RD_ARB_FIXED_PRIO_EN for lowest-index fixed priority instead of round-robin.
module bsg_axi_rd_arbiter #(
    parameter int num_masters_p    = 2,
    parameter int axi_id_width_p   = 4,
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 64,
    localparam int lg_masters_lp   = (num_masters_p > 1) ? $clog2(num_masters_p) : 1,
    localparam int sid_w_lp        = axi_id_width_p + lg_masters_lp
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,

    input  logic [num_masters_p*axi_id_width_p-1:0]   m_arid_i,
    input  logic [num_masters_p*axi_addr_width_p-1:0] m_araddr_i,
    input  logic [num_masters_p*2-1:0]                m_arburst_i,
    input  logic [num_masters_p-1:0]                  m_arvalid_i,
    output logic [num_masters_p-1:0]                  m_arready_o,

    output logic [axi_id_width_p-1:0]                 m_rid_o,
    output logic [axi_data_width_p-1:0]               m_rdata_o,
    output logic [1:0]                                m_rresp_o,
    output logic                                      m_rlast_o,
    output logic [num_masters_p-1:0]                  m_rvalid_o,
    input  logic [num_masters_p-1:0]                  m_rready_i,

    output logic [sid_w_lp-1:0]                       s_arid_o,
    output logic [axi_addr_width_p-1:0]               s_araddr_o,
    output logic [1:0]                                s_arburst_o,
    output logic                                      s_arvalid_o,
    input  logic                                      s_arready_i,

    input  logic [sid_w_lp-1:0]                       s_rid_i,
    input  logic [axi_data_width_p-1:0]               s_rdata_i,
    input  logic [1:0]                                s_rresp_i,
    input  logic                                      s_rlast_i,
    input  logic                                      s_rvalid_i,
    output logic                                      s_rready_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e                   state_r, state_n;
    logic [lg_masters_lp-1:0] grant_r, grant_n;
    logic [lg_masters_lp-1:0] sel;
    logic                     data_done;

    // Grantee selection, evaluated only while idle.
`ifdef BSG_AXI_RD_ARB_FIXED_PRIO_EN
    always_comb begin
        sel = '0;
        for (int i = num_masters_p - 1; i >= 0; i--) begin
            if (m_arvalid_i[i]) begin
                sel = lg_masters_lp'(i);
            end
        end
    end
`else
    logic [lg_masters_lp-1:0] last_grant_r;

    always_comb begin
        int  idx;
        logic found;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        // Search starts one past the last winner so every requester gets a turn.
        for (int i = 1; i <= num_masters_p; i++) begin
            idx = (int'(last_grant_r) + i) % num_masters_p;
            if (!found && m_arvalid_i[idx]) begin
                found = 1'b1;
                sel   = lg_masters_lp'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_grant_r <= lg_masters_lp'(num_masters_p - 1);
        end else if (data_done) begin
            last_grant_r <= grant_r;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            grant_r <= '0;
        end else begin
            state_r <= state_n;
            grant_r <= grant_n;
        end
    end

    assign data_done = (state_r == DATA) && s_rvalid_i && m_rready_i[grant_r] && s_rlast_i;

    always_comb begin
        state_n     = state_r;
        grant_n     = grant_r;
        s_arvalid_o = 1'b0;
        m_arready_o = '0;
        m_rvalid_o  = '0;
        s_rready_o  = 1'b0;
        unique case (state_r)
            IDLE: begin
                if (|m_arvalid_i) begin
                    grant_n = sel;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                s_arvalid_o          = 1'b1;
                m_arready_o[grant_r] = s_arready_i;
                if (s_arready_i) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                m_rvalid_o[grant_r] = s_rvalid_i;
                s_rready_o          = m_rready_i[grant_r];
                if (data_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // AR fields follow the latched grantee; only qualified by s_arvalid_o.
    assign s_arid_o    = {grant_r, m_arid_i[int'(grant_r)*axi_id_width_p +: axi_id_width_p]};
    assign s_araddr_o  = m_araddr_i[int'(grant_r)*axi_addr_width_p +: axi_addr_width_p];
    assign s_arburst_o = m_arburst_i[int'(grant_r)*2 +: 2];

    // Requester index in the upper ID bits is routing-only; strip it on the way back.
    assign m_rid_o   = s_rid_i[axi_id_width_p-1:0];
    assign m_rdata_o = s_rdata_i;
    assign m_rresp_o = s_rresp_i;
    assign m_rlast_o = s_rlast_i;

    logic unused_rid_idx;
    assign unused_rid_idx = ^s_rid_i[sid_w_lp-1:axi_id_width_p];

endmodule

// File: tb/tb_bsg_axi_rd_arbiter.sv
// Self-checking bench for bsg_axi_rd_arbiter: per-cycle vector table plus reset corner cases.
module tb_bsg_axi_rd_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [7:0]  m_arid_i;
    logic [63:0] m_araddr_i;
    logic [3:0]  m_arburst_i;
    logic [1:0]  m_arvalid_i;
    logic [1:0]  m_arready_o;
    logic [3:0]  m_rid_o;
    logic [63:0] m_rdata_o;
    logic [1:0]  m_rresp_o;
    logic        m_rlast_o;
    logic [1:0]  m_rvalid_o;
    logic [1:0]  m_rready_i;
    logic [4:0]  s_arid_o;
    logic [31:0] s_araddr_o;
    logic [1:0]  s_arburst_o;
    logic        s_arvalid_o;
    logic        s_arready_i;
    logic [4:0]  s_rid_i;
    logic [63:0] s_rdata_i;
    logic [1:0]  s_rresp_i;
    logic        s_rlast_i;
    logic        s_rvalid_i;
    logic        s_rready_o;

    bsg_axi_rd_arbiter dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .m_arid_i    (m_arid_i),
        .m_araddr_i  (m_araddr_i),
        .m_arburst_i (m_arburst_i),
        .m_arvalid_i (m_arvalid_i),
        .m_arready_o (m_arready_o),
        .m_rid_o     (m_rid_o),
        .m_rdata_o   (m_rdata_o),
        .m_rresp_o   (m_rresp_o),
        .m_rlast_o   (m_rlast_o),
        .m_rvalid_o  (m_rvalid_o),
        .m_rready_i  (m_rready_i),
        .s_arid_o    (s_arid_o),
        .s_araddr_o  (s_araddr_o),
        .s_arburst_o (s_arburst_o),
        .s_arvalid_o (s_arvalid_o),
        .s_arready_i (s_arready_i),
        .s_rid_i     (s_rid_i),
        .s_rdata_i   (s_rdata_i),
        .s_rresp_i   (s_rresp_i),
        .s_rlast_i   (s_rlast_i),
        .s_rvalid_i  (s_rvalid_i),
        .s_rready_o  (s_rready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  arvalid;
        logic        arready;
        logic        rvalid;
        logic        rlast;
        logic [1:0]  rready;
        logic [4:0]  rid;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic        e_arvalid;
        logic [4:0]  e_arid;
        logic [31:0] e_addr;
        logic [1:0]  e_burst;
        logic [1:0]  e_arready;
        logic [1:0]  e_rvalid;
        logic        e_rready;
        logic [3:0]  e_rid;
    } vec_t;

    localparam int NumVec = 21;
    vec_t vecs[NumVec];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [1:0] arvalid, input logic arready,
                                input logic rvalid, input logic rlast, input logic [1:0] rready,
                                input logic [4:0] rid, input logic e_arvalid,
                                input logic [4:0] e_arid, input logic [31:0] e_addr,
                                input logic [1:0] e_arready, input logic [1:0] e_rvalid,
                                input logic e_rready, input logic [3:0] e_rid);
        vec_t v;
        v.arvalid   = arvalid;
        v.arready   = arready;
        v.rvalid    = rvalid;
        v.rlast     = rlast;
        v.rready    = rready;
        v.rid       = rid;
        v.rdata     = 64'h0;
        v.rresp     = 2'b00;
        v.e_arvalid = e_arvalid;
        v.e_arid    = e_arid;
        v.e_addr    = e_addr;
        v.e_burst   = (e_addr == 32'h2000) ? 2'b10 : 2'b01;
        v.e_arready = e_arready;
        v.e_rvalid  = e_rvalid;
        v.e_rready  = e_rready;
        v.e_rid     = e_rid;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        m_arvalid_i = v.arvalid;
        s_arready_i = v.arready;
        s_rvalid_i  = v.rvalid;
        s_rlast_i   = v.rlast;
        m_rready_i  = v.rready;
        s_rid_i     = v.rid;
        s_rdata_i   = v.rdata;
        s_rresp_i   = v.rresp;
    endtask

    task automatic check_vec(input int i);
        vec_t e;
        string t;
        e = sb.pop_front();
        t = $sformatf("v%0d", i);
        cmp({t, " s_arvalid"}, 64'(s_arvalid_o), 64'(e.e_arvalid));
        if (e.e_arvalid) begin
            cmp({t, " s_arid"}, 64'(s_arid_o), 64'(e.e_arid));
            cmp({t, " s_araddr"}, 64'(s_araddr_o), 64'(e.e_addr));
            cmp({t, " s_arburst"}, 64'(s_arburst_o), 64'(e.e_burst));
        end
        cmp({t, " m_arready"}, 64'(m_arready_o), 64'(e.e_arready));
        cmp({t, " m_rvalid"}, 64'(m_rvalid_o), 64'(e.e_rvalid));
        cmp({t, " s_rready"}, 64'(s_rready_o), 64'(e.e_rready));
        cmp({t, " m_rid"}, 64'(m_rid_o), 64'(e.e_rid));
        cmp({t, " m_rdata"}, m_rdata_o, e.rdata);
        cmp({t, " m_rresp"}, 64'(m_rresp_o), 64'(e.rresp));
        cmp({t, " m_rlast"}, 64'(m_rlast_o), 64'(e.rlast));
    endtask

    task automatic check_idle_outputs(input string nm);
        cmp({nm, " s_arvalid"}, 64'(s_arvalid_o), 64'h0);
        cmp({nm, " m_arready"}, 64'(m_arready_o), 64'h0);
        cmp({nm, " m_rvalid"}, 64'(m_rvalid_o), 64'h0);
        cmp({nm, " s_rready"}, 64'(s_rready_o), 64'h0);
    endtask

    initial begin
        // Master 0: id 3, addr 0x1000, INCR; master 1: id 9, addr 0x2000, WRAP.
        m_arid_i    = {4'h9, 4'h3};
        m_araddr_i  = {32'h2000, 32'h1000};
        m_arburst_i = {2'b10, 2'b01};
        reset_i     = 1'b1;
        drive(mk(2'b11, 1, 1, 0, 2'b11, 5'h0, 0, 5'h0, 32'h0, 2'b00, 2'b00, 0, 4'h0));

        vecs[0]  = mk(2'b11, 0, 0, 0, 2'b00, 5'h00, 0, 5'h00, 32'h0,    2'b00, 2'b00, 0, 4'h0);
        vecs[1]  = mk(2'b11, 0, 0, 0, 2'b00, 5'h00, 1, 5'h03, 32'h1000, 2'b00, 2'b00, 0, 4'h0);
        vecs[2]  = vecs[1];
        vecs[3]  = vecs[1];
        vecs[4]  = mk(2'b11, 1, 0, 0, 2'b00, 5'h00, 1, 5'h03, 32'h1000, 2'b01, 2'b00, 0, 4'h0);
        vecs[5]  = mk(2'b10, 0, 1, 1, 2'b01, 5'h03, 0, 5'h00, 32'h0,    2'b00, 2'b01, 1, 4'h3);
        vecs[6]  = mk(2'b10, 0, 0, 0, 2'b00, 5'h00, 0, 5'h00, 32'h0,    2'b00, 2'b00, 0, 4'h0);
        vecs[7]  = mk(2'b10, 1, 0, 0, 2'b00, 5'h00, 1, 5'h19, 32'h2000, 2'b10, 2'b00, 0, 4'h0);
        vecs[8]  = mk(2'b00, 0, 1, 0, 2'b10, 5'h15, 0, 5'h00, 32'h0,    2'b00, 2'b10, 1, 4'h5);
        vecs[9]  = mk(2'b00, 0, 1, 0, 2'b00, 5'h15, 0, 5'h00, 32'h0,    2'b00, 2'b10, 0, 4'h5);
        vecs[10] = mk(2'b00, 0, 1, 0, 2'b10, 5'h15, 0, 5'h00, 32'h0,    2'b00, 2'b10, 1, 4'h5);
        vecs[11] = vecs[10];
        vecs[12] = mk(2'b00, 0, 1, 1, 2'b10, 5'h15, 0, 5'h00, 32'h0,    2'b00, 2'b10, 1, 4'h5);
        vecs[13] = mk(2'b00, 0, 1, 0, 2'b11, 5'h15, 0, 5'h00, 32'h0,    2'b00, 2'b00, 0, 4'h5);
        vecs[14] = mk(2'b11, 0, 0, 0, 2'b00, 5'h00, 0, 5'h00, 32'h0,    2'b00, 2'b00, 0, 4'h0);
        vecs[15] = mk(2'b11, 1, 0, 0, 2'b00, 5'h00, 1, 5'h03, 32'h1000, 2'b01, 2'b00, 0, 4'h0);
        vecs[16] = mk(2'b11, 0, 1, 1, 2'b01, 5'h03, 0, 5'h00, 32'h0,    2'b00, 2'b01, 1, 4'h3);
        vecs[17] = mk(2'b11, 0, 0, 0, 2'b00, 5'h00, 0, 5'h00, 32'h0,    2'b00, 2'b00, 0, 4'h0);
`ifdef BSG_AXI_RD_ARB_FIXED_PRIO_EN
        vecs[18] = mk(2'b11, 1, 0, 0, 2'b00, 5'h00, 1, 5'h03, 32'h1000, 2'b01, 2'b00, 0, 4'h0);
        vecs[19] = mk(2'b00, 0, 1, 1, 2'b11, 5'h03, 0, 5'h00, 32'h0,    2'b00, 2'b01, 1, 4'h3);
`else
        vecs[18] = mk(2'b11, 1, 0, 0, 2'b00, 5'h00, 1, 5'h19, 32'h2000, 2'b10, 2'b00, 0, 4'h0);
        vecs[19] = mk(2'b00, 0, 1, 1, 2'b11, 5'h15, 0, 5'h00, 32'h0,    2'b00, 2'b10, 1, 4'h5);
`endif
        vecs[20] = mk(2'b00, 0, 0, 0, 2'b00, 5'h00, 0, 5'h00, 32'h0,    2'b00, 2'b00, 0, 4'h0);
        for (int i = 0; i < NumVec; i++) begin
            vecs[i].rdata = 64'hA5A5_0000_0000_0000 | 64'(i * 17);
            vecs[i].rresp = 2'(i);
        end

        // Reset held with every input asserted: outputs must stay quiet.
        @(negedge clk_i);
        @(negedge clk_i);
        check_idle_outputs("reset");
        drive(mk(2'b00, 0, 0, 0, 2'b00, 5'h0, 0, 5'h0, 32'h0, 2'b00, 2'b00, 0, 4'h0));
        reset_i = 1'b0;

        for (int i = 0; i < NumVec; i++) begin
            @(negedge clk_i);
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            #2;
            check_vec(i);
        end

        // Master 1 bursts; reset lands during the second data beat.
        @(negedge clk_i);
        m_arvalid_i = 2'b10;
        @(negedge clk_i);
        s_arready_i = 1'b1;
        #2;
        cmp("pre_rst s_arvalid", 64'(s_arvalid_o), 64'h1);
        @(negedge clk_i);
        m_arvalid_i = 2'b00;
        s_arready_i = 1'b0;
        s_rvalid_i  = 1'b1;
        s_rlast_i   = 1'b0;
        m_rready_i  = 2'b10;
        s_rid_i     = 5'h15;
        #2;
        cmp("beat1 m_rvalid", 64'(m_rvalid_o), 64'h2);
        @(negedge clk_i);
        #1 reset_i = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk_i);
        reset_i    = 1'b0;
        s_rvalid_i = 1'b0;
        m_rready_i = 2'b00;
        m_arvalid_i = 2'b10;
        #2;
        check_idle_outputs("post_rst idle");
        @(negedge clk_i);
        s_arready_i = 1'b1;
        #2;
        cmp("post_rst s_arvalid", 64'(s_arvalid_o), 64'h1);
        cmp("post_rst s_arid", 64'(s_arid_o), 64'h19);
        cmp("post_rst m_arready", 64'(m_arready_o), 64'h2);
        @(negedge clk_i);
        m_arvalid_i = 2'b00;
        s_arready_i = 1'b0;
        s_rvalid_i  = 1'b1;
        s_rlast_i   = 1'b1;
        m_rready_i  = 2'b10;
        #2;
        cmp("post_rst m_rvalid", 64'(m_rvalid_o), 64'h2);
        cmp("post_rst s_rready", 64'(s_rready_o), 64'h1);
        @(negedge clk_i);
        #2;
        check_idle_outputs("post_rst done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_axi_rd_arbiter.md
BSG_AXI_RD_ARBITER -- requirements
Module: bsg_axi_rd_arbiter

Interface
REQ-001 Parameter num_masters_p, default 2, number of AXI read requesters (2..8).
REQ-002 Parameter axi_id_width_p, default 4, requester-side ID width.
REQ-003 Parameter axi_addr_width_p, default 32, address width; axi_data_width_p, default 64, data width.
REQ-004 Derived lg_masters_lp = BSG_SAFE_CLOG2(num_masters_p); slave ID width sid_w = axi_id_width_p + lg_masters_lp.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 m_arid_i  in  num_masters_p*axi_id_width_p  per-requester AR ID, packed, requester 0 in LSBs.
REQ-008 m_araddr_i  in  num_masters_p*axi_addr_width_p  per-requester AR address.
REQ-009 m_arburst_i  in  num_masters_p*2  per-requester burst type.
REQ-010 m_arvalid_i  in  num_masters_p  per-requester AR valid.
REQ-011 m_arready_o  out  num_masters_p  per-requester AR ready.
REQ-012 m_rid_o  out  axi_id_width_p  returned ID, shared bus.
REQ-013 m_rdata_o  out  axi_data_width_p  read data, shared bus; m_rresp_o  out  2  response, shared; m_rlast_o  out  1  last beat, shared.
REQ-014 m_rvalid_o  out  num_masters_p  per-requester R valid; m_rready_i  in  num_masters_p  per-requester R ready.
REQ-015 s_arid_o  out  sid_w  {grantee index, grantee arid}; s_araddr_o  out  axi_addr_width_p; s_arburst_o  out  2.
REQ-016 s_arvalid_o  out  1; s_arready_i  in  1  slave AR handshake.
REQ-017 s_rid_i  in  sid_w; s_rdata_i  in  axi_data_width_p; s_rresp_i  in  2; s_rlast_i  in  1.
REQ-018 s_rvalid_i  in  1; s_rready_o  out  1  slave R handshake.

Function
REQ-019 FSM states SHALL be IDLE, ADDR, DATA; exactly one burst outstanding at a time.
REQ-020 IDLE: if any m_arvalid_i set, select grantee by round-robin starting at (last_grant_r+1) mod num_masters_p, latch grant_r, go to ADDR; else stay.
REQ-021 ADDR: s_arvalid_o=1, AR fields muxed from grant_r; m_arready_o[grant_r]=s_arready_i, all other bits 0; on s_arready_i go to DATA.
REQ-022 DATA: m_rvalid_o[grant_r]=s_rvalid_i, other bits 0; s_rready_o=m_rready_i[grant_r]; m_rdata_o/m_rresp_o/m_rlast_o pass through combinationally.
REQ-023 m_rid_o SHALL equal s_rid_i[axi_id_width_p-1:0]; upper index bits stripped.
REQ-024 DATA exits on s_rvalid_i & s_rready_o & s_rlast_i: last_grant_r<=grant_r, go to IDLE.
REQ-025 Latency: arvalid seen in IDLE at cycle N -> s_arvalid_o high at N+1; one idle cycle between bursts.
REQ-026 Single-beat burst (rlast on first beat) SHALL complete in one DATA cycle.
REQ-027 Non-grantee requests SHALL be held (arready 0) until grantee's burst ends; no starvation under round-robin.
REQ-028 Outside ADDR, s_arvalid_o=0 and m_arready_o=0; outside DATA, s_rready_o=0 and m_rvalid_o=0.

Reset
REQ-029 reset_i SHALL force state IDLE, grant_r=0, last_grant_r=num_masters_p-1 (requester 0 first priority) immediately, including mid-burst.
REQ-030 During and after reset all valid/ready outputs SHALL be 0 until a request is seen in IDLE.

Configuration
REQ-031 Macro BSG_AXI_RD_ARB_FIXED_PRIO_EN: defined -> IDLE selects lowest-index requesting master (fixed priority), last_grant_r unused; undefined -> round-robin per REQ-020.

Verification
REQ-032 After reset, m_arvalid_i=2'b11 simultaneously -> master 0 granted first, s_arid_o={1'b0,arid0}; master 1 granted after master 0's rlast.
REQ-033 Master 1 burst of 4 beats, s_rid_i={1'b1,4'h5} -> m_rvalid_o=2'b10 each beat, m_rid_o=4'h5, return to IDLE after 4th beat.
REQ-034 s_arready_i held 0 for 3 cycles -> s_arvalid_o and fields stable, m_arready_o=0 throughout, granted once arready=1.
REQ-035 m_rready_i[grant]=0 mid-burst -> s_rready_o=0, beat held; no other master sees rvalid.
REQ-036 reset_i asserted during DATA beat 2 -> outputs 0 asynchronously; next request from master 1 alone granted normally.
REQ-037 With BSG_AXI_RD_ARB_FIXED_PRIO_EN defined, both masters continuously requesting -> master 0 granted every burst.
